// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file write-port controller.
package rf_ctrl_pkg;

    localparam int unsigned AW_DEFAULT = 5;
    localparam int unsigned DW_DEFAULT = 32;
    localparam int unsigned NREGS      = 1 << AW_DEFAULT;
    localparam int unsigned LAST_REG   = NREGS - 1;

    typedef enum logic {
        CLEAR,
        RUN
    } rfc_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic; the priority pointer is held by the caller.
module rr_arb2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] grant
);

    // One-hot grant: a lone requester always wins, ptr breaks ties (0 favours req0).
    always_comb begin
        grant = '0;
        if (en) begin
            if (valid0 && (!valid1 || !ptr)) begin
                grant[0] = 1'b1;
            end else if (valid1) begin
                grant[1] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_write_ctrl.sv
// Shares the register-file write port between two requesters and zeroes
// r1..r(2^AW-1) after reset or on clr_req.
module rf_write_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          clr_busy,
    input  logic          req0_valid,
    input  logic          req1_valid,
    output logic          req0_ready,
    output logic          req1_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req0_data,
    input  logic [DW-1:0] req1_data,
    output logic          last_grant,
    output logic          rf_we3,
    output logic [AW-1:0] rf_wa3,
    output logic [DW-1:0] rf_wd3
);

    localparam logic [AW-1:0] FIRST_ADDR = AW'(1);
    localparam logic [AW-1:0] LAST_ADDR  = '1;

    rfc_state_t    state;
    rfc_state_t    next_state;
    logic [AW-1:0] cnt;
    logic          ptr;
    logic          arb_en;
    logic [1:0]    grant;
    logic          hs0;
    logic          hs1;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    rr_arb2 u_arb (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .ptr    (ptr),
        .en     (arb_en),
        .grant  (grant)
    );

    // Handshake qualification and write-data selection.
    always_comb begin
        arb_en     = (state == RUN) && !clr_req;
        req0_ready = grant[0];
        req1_ready = grant[1];
        hs0        = req0_valid && grant[0];
        hs1        = req1_valid && grant[1];
        sel_addr   = hs1 ? req1_addr : req0_addr;
        sel_data   = hs1 ? req1_data : req0_data;
        clr_busy   = (state == CLEAR);
    end

    // Next-state logic: clear runs to the last register, clr_req restarts it.
    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (cnt == LAST_ADDR) next_state = RUN;
            RUN:     if (clr_req)          next_state = CLEAR;
            default: next_state = CLEAR;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Clear counter: steps during CLEAR, parked at 1 in RUN so a new clear starts at r1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= FIRST_ADDR;
        end else if (state == CLEAR) begin
            cnt <= cnt + FIRST_ADDR;
        end else begin
            cnt <= FIRST_ADDR;
        end
    end

    // Arbitration pointer and last-grant record, updated on every handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= 1'b0;
            last_grant <= 1'b0;
        end else if (hs0) begin
            ptr        <= 1'b1;
            last_grant <= 1'b0;
        end else if (hs1) begin
            ptr        <= 1'b0;
            last_grant <= 1'b1;
        end
    end

    // Registered write port: zero writes in CLEAR, accepted writes in RUN.
    // A handshake to r0 is treated like no write, so address/data hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we3 <= 1'b0;
            rf_wa3 <= '0;
            rf_wd3 <= '0;
        end else if (state == CLEAR) begin
            rf_we3 <= 1'b1;
            rf_wa3 <= cnt;
            rf_wd3 <= '0;
        end else if ((hs0 || hs1) && (sel_addr != '0)) begin
            rf_we3 <= 1'b1;
            rf_wa3 <= sel_addr;
            rf_wd3 <= sel_data;
        end else begin
            rf_we3 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Directed bench for rf_write_ctrl with a behavioural register-file model.
module tb_rf_write_ctrl;

    logic        clk;
    logic        rst_n;
    logic        clr_req;
    logic        clr_busy;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_ready;
    logic        req1_ready;
    logic [4:0]  req0_addr;
    logic [4:0]  req1_addr;
    logic [31:0] req0_data;
    logic [31:0] req1_data;
    logic        last_grant;
    logic        rf_we3;
    logic [4:0]  rf_wa3;
    logic [31:0] rf_wd3;

    int tests;
    int fails;

    rf_write_ctrl #(.AW(5), .DW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_addr  (req0_addr),
        .req1_addr  (req1_addr),
        .req0_data  (req0_data),
        .req1_data  (req1_data),
        .last_grant (last_grant),
        .rf_we3     (rf_we3),
        .rf_wa3     (rf_wa3),
        .rf_wd3     (rf_wd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: commits the port at the edge ending the write cycle.
    logic [31:0] mem [32];
    logic [31:0] wr_mask = '0;
    always @(posedge clk) begin
        if (rf_we3 && rf_wa3 != 5'd0) begin
            mem[rf_wa3]     <= rf_wd3;
            wr_mask[rf_wa3] <= 1'b1;
        end
    end

    function automatic logic [31:0] rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (!wr_mask[a]) return 32'hDEAD_BEEF;
        return mem[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        e_r0;
        logic        e_r1;
        logic        e_we;
        logic        chk_wa;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_lg;
    } vec_t;

    vec_t vecs [12];

    // Entered and left at a falling edge.
    task automatic apply(input vec_t v, input string tag);
        req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
        req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
        #1;
        check({tag, " req0_ready"}, 32'(req0_ready), 32'(v.e_r0));
        check({tag, " req1_ready"}, 32'(req1_ready), 32'(v.e_r1));
        @(posedge clk); #1;
        check({tag, " rf_we3"}, 32'(rf_we3), 32'(v.e_we));
        if (v.chk_wa) begin
            check({tag, " rf_wa3"}, 32'(rf_wa3), 32'(v.e_wa));
            check({tag, " rf_wd3"}, rf_wd3, v.e_wd);
        end
        check({tag, " last_grant"}, 32'(last_grant), 32'(v.e_lg));
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Walks a full clear from r1 to r31; req0_valid may be held meanwhile.
    task automatic run_clear(input string tag, input int unsigned last_k);
        for (int unsigned k = 1; k <= last_k; k++) begin
            check({tag, " clr_busy"}, 32'(clr_busy), 32'd1);
            check({tag, " ready0 blocked"}, 32'(req0_ready), 32'd0);
            @(posedge clk); #1;
            check({tag, " clr we"}, 32'(rf_we3), 32'd1);
            check({tag, " clr wa"}, 32'(rf_wa3), 32'(k));
            check({tag, " clr wd"}, rf_wd3, 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic pulse_clr(input string tag);
        clr_req = 1'b1;
        #1;
        check({tag, " ready0 in clr_req"}, 32'(req0_ready), 32'd0);
        check({tag, " busy before"}, 32'(clr_busy), 32'd0);
        @(posedge clk); #1;
        check({tag, " busy after"}, 32'(clr_busy), 32'd1);
        check({tag, " we after clr_req"}, 32'(rf_we3), 32'd0);
        @(negedge clk);
        clr_req = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        clr_req = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h22;

        //           v0  a0     d0           v1  a1     d1        r0 r1 we chk wa    wd          lg
        vecs[0]  = '{1, 5'd6,  32'hCA,      0, 5'd0,  32'h0,     1, 0, 1, 1, 5'd6,  32'hCA,     0};
        vecs[1]  = '{0, 5'd0,  32'h0,       0, 5'd0,  32'h0,     0, 0, 0, 1, 5'd6,  32'hCA,     0};
        vecs[2]  = '{0, 5'd0,  32'h0,       1, 5'd0,  32'hD,     0, 1, 0, 0, 5'd0,  32'h0,      1};
        vecs[3]  = '{1, 5'd2,  32'hC,       1, 5'd4,  32'hA,     1, 0, 1, 1, 5'd2,  32'hC,      0};
        vecs[4]  = '{1, 5'd2,  32'hC,       1, 5'd4,  32'hA,     0, 1, 1, 1, 5'd4,  32'hA,      1};
        vecs[5]  = '{1, 5'd2,  32'hC,       1, 5'd4,  32'hA,     1, 0, 1, 1, 5'd2,  32'hC,      0};
        vecs[6]  = '{1, 5'd2,  32'hC,       1, 5'd4,  32'hA,     0, 1, 1, 1, 5'd4,  32'hA,      1};
        vecs[7]  = '{1, 5'd31, 32'h55,      0, 5'd0,  32'h0,     1, 0, 1, 1, 5'd31, 32'h55,     0};
        vecs[8]  = '{0, 5'd0,  32'h0,       0, 5'd0,  32'h0,     0, 0, 0, 1, 5'd31, 32'h55,     0};
        vecs[9]  = '{0, 5'd0,  32'h0,       1, 5'd9,  32'h77,    0, 1, 1, 1, 5'd9,  32'h77,     1};
        vecs[10] = '{0, 5'd0,  32'h0,       1, 5'd10, 32'h88,    0, 1, 1, 1, 5'd10, 32'h88,     1};
        vecs[11] = '{0, 5'd0,  32'h0,       0, 5'd0,  32'h0,     0, 0, 0, 1, 5'd10, 32'h88,     1};

        // Reset values, with both valids asserted to show readies stay low.
        repeat (2) @(negedge clk);
        #1;
        check("rst rf_we3", 32'(rf_we3), 32'd0);
        check("rst rf_wa3", 32'(rf_wa3), 32'd0);
        check("rst rf_wd3", rf_wd3, 32'd0);
        check("rst last_grant", 32'(last_grant), 32'd0);
        check("rst clr_busy", 32'(clr_busy), 32'd1);
        check("rst req0_ready", 32'(req0_ready), 32'd0);
        check("rst req1_ready", 32'(req1_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;

        run_clear("boot", 31);
        check("boot busy done", 32'(clr_busy), 32'd0);
        check("boot r6", rd(5'd6), 32'd0);

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end
        check("r6", rd(5'd6), 32'hCA);
        check("r2", rd(5'd2), 32'hC);
        check("r4", rd(5'd4), 32'hA);
        check("r0", rd(5'd0), 32'h0);
        check("r31", rd(5'd31), 32'h55);
        check("r10", rd(5'd10), 32'h88);

        // Clear on command with req0 held valid through the whole clear.
        req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'h1234;
        pulse_clr("cmd");
        run_clear("cmd", 31);
        check("cmd busy done", 32'(clr_busy), 32'd0);
        check("cmd r6 cleared", rd(5'd6), 32'd0);
        #1;
        check("held req0 ready", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        check("held we", 32'(rf_we3), 32'd1);
        check("held wa", 32'(rf_wa3), 32'd12);
        check("held wd", rf_wd3, 32'h1234);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        check("r12", rd(5'd12), 32'h1234);

        // Reset in the middle of a clear.
        apply('{0, 5'd0, 32'h0, 1, 5'd3, 32'h33, 0, 1, 1, 1, 5'd3, 32'h33, 1}, "pre");
        pulse_clr("mid");
        run_clear("mid", 9);
        rst_n = 1'b0;
        #1;
        check("mid rst we", 32'(rf_we3), 32'd0);
        check("mid rst wa", 32'(rf_wa3), 32'd0);
        check("mid rst lg", 32'(last_grant), 32'd0);
        check("mid rst busy", 32'(clr_busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_clear("restart", 31);
        check("restart busy done", 32'(clr_busy), 32'd0);
        apply('{1, 5'd7, 32'h77, 0, 5'd0, 32'h0, 1, 0, 1, 1, 5'd7, 32'h77, 0}, "post");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
